// File: rtl/ser2par_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deframer.
package ser2par_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;

  // Counter must address every data bit; keep at least one bit for tiny widths.
  function automatic int cnt_w_f(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/ser2par_hold.sv
// One-entry output holding register: loads a completed word, 0-cycle accept/refill.
// Backpressure: holds while out_valid&!out_ready; a word arriving then is dropped and flagged via ovf.
module ser2par_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_vld,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             load_perr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_perr,
  output logic             ovf
);

  logic accept;

  // Free slot, or the held word leaves on this same edge.
  assign accept = !out_valid || out_ready;
  assign ovf    = load_vld && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_perr  <= 1'b0;
    end else if (load_vld && accept) begin
      out_valid <= 1'b1;
      out_data  <= load_dat;
      out_perr  <= load_perr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ser2par_deframer.sv
// Framed LSB-first serial to WIDTH-bit words; out_valid 1 cycle after the last bit, sticky ovf/abort flags.
// Backpressure via one-entry hold register; optional parity bit with SER2PAR_PARITY_EN.
module ser2par_deframer
  import ser2par_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int CNT_W = cnt_w_f(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_perr,
  output logic             err_ovf,
  output logic             err_abort,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sreg;

  logic             word_done;
  logic [WIDTH-1:0] word_dat;
  logic             word_perr;
  logic             abort_evt;
  logic             ovf;

  always_comb begin
    word_done = 1'b0;
    word_dat  = sreg;
    word_perr = 1'b0;
    abort_evt = in_valid && in_start && (state != IDLE);
`ifdef SER2PAR_PARITY_EN
    if (state == PARITY && in_valid && !in_start) begin
      word_done = 1'b1;
      word_perr = (^sreg) ^ in_bit;
    end
`else
    if (state == SHIFT && in_valid && !in_start && cnt == LAST) begin
      word_done           = 1'b1;
      word_dat[WIDTH-1]   = in_bit;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else if (in_valid) begin
      if (in_start) begin
        // New frame, or restart mid-frame: drop any partial bits.
        state <= SHIFT;
        cnt   <= CNT_W'(1);
        sreg  <= {{(WIDTH-1){1'b0}}, in_bit};
      end else begin
        case (state)
          SHIFT: begin
            sreg[cnt] <= in_bit;
            if (cnt == LAST) begin
              cnt <= '0;
`ifdef SER2PAR_PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
`ifdef SER2PAR_PARITY_EN
          PARITY: state <= IDLE;
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  ser2par_hold #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_vld  (word_done),
    .load_dat  (word_dat),
    .load_perr (word_perr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_perr  (out_perr),
    .ovf       (ovf)
  );

  // Clear wins over a same-cycle set; that event is not remembered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf   <= 1'b0;
      err_abort <= 1'b0;
    end else if (err_clr) begin
      err_ovf   <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      if (ovf)       err_ovf   <= 1'b1;
      if (abort_evt) err_abort <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ser2par_deframer.sv
// Scoreboard bench for ser2par_deframer (WIDTH=8), with or without SER2PAR_PARITY_EN.
module tb_ser2par_deframer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_bit = 1'b0;
  logic         in_start = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_perr;
  logic         err_ovf;
  logic         err_abort;
  logic         err_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  ser2par_deframer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_start  (in_start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_perr  (out_perr),
    .err_ovf   (err_ovf),
    .err_abort (err_abort),
    .err_clr   (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every accepted word is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 32'(out_data), 32'hdead);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("sb_data", 32'(out_data), 32'(e[W-1:0]));
        check("sb_perr", 32'(out_perr), 32'(e[W]));
      end
    end
  end

  task automatic drive_bit(input logic b, input logic st);
    in_valid = 1'b1;
    in_bit   = b;
    in_start = st;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // stall_at: bit index before which stall_n idle cycles are inserted.
  // pflip: parity bit sent is even parity XOR pflip (only when parity is built in).
  task automatic send_word(input logic [W-1:0] d, input logic push, input logic rdy_last,
                           input int stall_at, input int stall_n, input logic pflip);
    logic exp_perr;
`ifdef SER2PAR_PARITY_EN
    exp_perr = pflip;
`else
    exp_perr = 1'b0;
`endif
    if (push) exp_q.push_back({exp_perr, d});
    for (int i = 0; i < W; i++) begin
      if (i == stall_at) idle(stall_n);
`ifndef SER2PAR_PARITY_EN
      if (i == W - 1 && rdy_last) out_ready = 1'b1;
`endif
      drive_bit(d[i], i == 0);
    end
`ifdef SER2PAR_PARITY_EN
    if (rdy_last) out_ready = 1'b1;
    drive_bit((^d) ^ pflip, 1'b0);
`endif
  endtask

  initial begin
    idle(2);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data",  32'(out_data),  32'h0);
    check("rst_perr",  32'(out_perr),  32'h0);
    check("rst_ovf",   32'(err_ovf),   32'h0);
    check("rst_abort", 32'(err_abort), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, consumer always ready: valid for exactly one cycle.
    out_ready = 1'b1;
    send_word(8'hA5, 1'b1, 1'b0, -1, 0, 1'b0);
    check("a5_valid", 32'(out_valid), 32'h1);
    check("a5_data",  32'(out_data),  32'hA5);
    idle(1);
    check("a5_once",  32'(out_valid), 32'h0);
    check("a5_ovf",   32'(err_ovf),   32'h0);
    check("a5_abort", 32'(err_abort), 32'h0);

    // Three stall cycles mid-frame.
    send_word(8'h3C, 1'b1, 1'b0, 4, 3, 1'b0);
    check("stall_data", 32'(out_data), 32'h3C);
    idle(1);

    // Overrun: second word dropped, first held.
    out_ready = 1'b0;
    send_word(8'h11, 1'b1, 1'b0, -1, 0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, -1, 0, 1'b0);
    check("ovf_hold", 32'(out_data),  32'h11);
    check("ovf_vld",  32'(out_valid), 32'h1);
    check("ovf_flag", 32'(err_ovf),   32'h1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("ovf_clr",  32'(err_ovf),   32'h0);
    out_ready = 1'b1;
    idle(1);
    check("ovf_drain", 32'(out_valid), 32'h0);

    // Drain and refill on the same edge.
    out_ready = 1'b0;
    send_word(8'h55, 1'b1, 1'b0, -1, 0, 1'b0);
    idle(1);
    send_word(8'hAA, 1'b1, 1'b1, -1, 0, 1'b0);
    check("refill_vld",  32'(out_valid), 32'h1);
    check("refill_data", 32'(out_data),  32'hAA);
    check("refill_ovf",  32'(err_ovf),   32'h0);
    idle(1);

    // Abort after 4 bits, restart with 0xF0: no stale ones in the low nibble.
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    send_word(8'hF0, 1'b1, 1'b0, -1, 0, 1'b0);
    check("abort_flag", 32'(err_abort), 32'h1);
    check("abort_data", 32'(out_data),  32'hF0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("abort_clr", 32'(err_abort), 32'h0);

    // Async reset mid-frame with a held word and a set flag.
    out_ready = 1'b0;
    send_word(8'h99, 1'b1, 1'b0, -1, 0, 1'b0);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b0);
    check("pre_rst_abort", 32'(err_abort), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_data",  32'(out_data),  32'h0);
    check("arst_abort", 32'(err_abort), 32'h0);
    check("arst_ovf",   32'(err_ovf),   32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    out_ready = 1'b1;
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    check("idle_discard", 32'(out_valid), 32'h0);
    send_word(8'h5A, 1'b1, 1'b0, -1, 0, 1'b0);
    check("post_rst_data", 32'(out_data), 32'h5A);

`ifdef SER2PAR_PARITY_EN
    send_word(8'h07, 1'b1, 1'b0, -1, 0, 1'b0);
    check("par_ok", 32'(out_perr), 32'h0);
    send_word(8'h07, 1'b1, 1'b0, -1, 0, 1'b1);
    check("par_bad", 32'(out_perr), 32'h1);
`endif

    // Bounded wait for the scoreboard to empty.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    check("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
